// File: rtl/i2c_master_regs_fifo_pkg.sv
// Shared register map, bit positions and command layout for the I2C master register block.
package i2c_master_defines;

   localparam int ISR_W = 6;

   // Register addresses
   localparam logic [2:0] ADDR_PRERLO = 3'd0;
   localparam logic [2:0] ADDR_PRERHI = 3'd1;
   localparam logic [2:0] ADDR_CTR    = 3'd2;
   localparam logic [2:0] ADDR_DATA   = 3'd3;
   localparam logic [2:0] ADDR_CR     = 3'd4;
   localparam logic [2:0] ADDR_IER    = 3'd5;
   localparam logic [2:0] ADDR_ISR    = 3'd6;
   localparam logic [2:0] ADDR_LVL    = 3'd7;

   // CTR bits
   localparam int CTR_EN  = 7;
   localparam int CTR_IEN = 6;

   // CR bits
   localparam int CR_STA = 7;
   localparam int CR_STO = 6;
   localparam int CR_RD  = 5;
   localparam int CR_WR  = 4;
   localparam int CR_ACK = 3;

   // SR bits
   localparam int SR_RXACK = 7;
   localparam int SR_BUSY  = 6;
   localparam int SR_AL    = 5;
   localparam int SR_TXF   = 4;
   localparam int SR_RXE   = 3;
   localparam int SR_TIP   = 1;
   localparam int SR_IF    = 0;

   // ISR bits
   localparam int ISR_DONE   = 0;
   localparam int ISR_AL     = 1;
   localparam int ISR_TXE    = 2;
   localparam int ISR_RXTH   = 3;
   localparam int ISR_RXOVF  = 4;
   localparam int ISR_CMDERR = 5;

   // Command register contents, same order as CR[7:3]
   typedef struct packed {
      logic sta;
      logic sto;
      logic rd;
      logic wr;
      logic ack;
   } cmd_t;

endpackage

// File: rtl/i2c_master_regs_fifo_sync_fifo.sv
// Synchronous FIFO with occupancy count; head reads as zero while empty.
module i2c_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_q, wr_q;
   logic [CW-1:0]    cnt_q;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign dout_o  = empty_o ? '0 : mem_q[rd_q];

   // A pop frees the slot in the same cycle, so push-while-full succeeds alongside a pop
   assign do_push = push_i & (~full_o | pop_i);
   assign do_pop  = pop_i & ~empty_o;

   // Storage, pointers and count
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= din_i;
            wr_q        <= wr_q + 1'b1;
         end
         if (do_pop) rd_q <= rd_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/i2c_master_regs_fifo.sv
// Host register file for the I2C byte controller with TX/RX FIFOs and W1C interrupts.
module i2c_master_regs_fifo
   import i2c_master_defines::*;
#(
   parameter int DWIDTH    = 8,
   parameter int AWIDTH    = 3,
   parameter int DEPTH     = 4,
   parameter int RX_THRESH = 2
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic [AWIDTH-1:0] Addr,
   input  logic [DWIDTH-1:0] DataIn,
   output logic [DWIDTH-1:0] DataOut,
   input  logic              Wr,
   input  logic              Rd,
   output logic              Int,
   output logic              Start,
   output logic              Stop,
   output logic              Read,
   output logic              Write,
   output logic              Tx_ack,
   output logic [DWIDTH-1:0] Tx_data,
   output logic [15:0]       Prescale,
   output logic              I2C_en,
   input  logic [DWIDTH-1:0] Rx_data,
   input  logic              Rx_ack,
   input  logic              I2C_busy,
   input  logic              I2C_done,
   input  logic              I2C_al
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [15:0]       prer_q, prer_d;
   logic [1:0]        ctr_q, ctr_d;   // {EN, IEN}
   cmd_t              cmd_q, cmd_d;
   logic [ISR_W-1:0]  ier_q, ier_d, isr_q, isr_d, isr_set, isr_clr;
   logic              rxack_q, rxack_d, int_q, int_d;

   logic              tx_push, tx_pop, tx_full, tx_empty;
   logic              rx_push, rx_pop, rx_full, rx_empty;
   logic              rx_push_eff, rx_pop_eff, done_ev, tip;
   logic [CW-1:0]     tx_count, rx_count;
   logic [DWIDTH-1:0] rx_head;
   logic [7:0]        sr;

   i2c_sync_fifo #(.WIDTH(DWIDTH), .DEPTH(DEPTH)) u_tx_fifo (
      .clk_i(Clk), .rst_i(Rst), .push_i(tx_push), .pop_i(tx_pop), .din_i(DataIn),
      .dout_o(Tx_data), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_count)
   );

   i2c_sync_fifo #(.WIDTH(DWIDTH), .DEPTH(DEPTH)) u_rx_fifo (
      .clk_i(Clk), .rst_i(Rst), .push_i(rx_push), .pop_i(rx_pop), .din_i(Rx_data),
      .dout_o(rx_head), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_count)
   );

   assign tip      = cmd_q.sta | cmd_q.sto | cmd_q.rd | cmd_q.wr;
   assign Start    = cmd_q.sta;
   assign Stop     = cmd_q.sto;
   assign Read     = cmd_q.rd;
   assign Write    = cmd_q.wr;
   assign Tx_ack   = cmd_q.ack;
   assign Prescale = prer_q;
   assign I2C_en   = ctr_q[1];
   assign Int      = int_q;

   // Arbitration loss overrides a coincident completion: no FIFO traffic then
   assign done_ev     = I2C_done & ~I2C_al;
   assign tx_pop      = done_ev & cmd_q.wr;
   assign rx_push     = done_ev & cmd_q.rd;
   assign tx_push     = Wr & (Addr == ADDR_DATA);
   assign rx_pop      = Rd & (Addr == ADDR_DATA);
   assign rx_push_eff = rx_push & (~rx_full | rx_pop);
   assign rx_pop_eff  = rx_pop & ~rx_empty;

   // Next-state for registers, command acceptance and interrupt events
   always_comb begin
      prer_d  = prer_q;
      ctr_d   = ctr_q;
      ier_d   = ier_q;
      cmd_d   = cmd_q;
      rxack_d = rxack_q;
      isr_set = '0;
      isr_clr = '0;

      if (I2C_done | I2C_al) begin
         cmd_d.sta = 1'b0;
         cmd_d.sto = 1'b0;
         cmd_d.rd  = 1'b0;
         cmd_d.wr  = 1'b0;
      end
      if (done_ev) rxack_d = Rx_ack;

      isr_set[ISR_DONE]  = I2C_done;
      isr_set[ISR_AL]    = I2C_al;
      isr_set[ISR_TXE]   = tx_pop & (tx_count == CW'(1)) & ~tx_push;
      isr_set[ISR_RXTH]  = rx_push_eff & ~rx_pop_eff & (rx_count == CW'(RX_THRESH - 1));
      isr_set[ISR_RXOVF] = rx_push & rx_full & ~rx_pop;
      if (tx_push & tx_full & ~tx_pop) isr_set[ISR_CMDERR] = 1'b1;

      if (Wr) begin
         case (Addr)
            ADDR_PRERLO: prer_d[7:0]  = DataIn;
            ADDR_PRERHI: prer_d[15:8] = DataIn;
            ADDR_CTR:    ctr_d        = {DataIn[CTR_EN], DataIn[CTR_IEN]};
            ADDR_IER:    ier_d        = DataIn[ISR_W-1:0];
            ADDR_ISR:    isr_clr      = DataIn[ISR_W-1:0];
            ADDR_CR: begin
               if (tip || (DataIn[CR_RD] && DataIn[CR_WR]) ||
                   (DataIn[CR_RD] && rx_full) || (DataIn[CR_WR] && tx_empty))
                  isr_set[ISR_CMDERR] = 1'b1;
               else
                  cmd_d = cmd_t'(DataIn[CR_STA:CR_ACK]);
            end
            default: ;
         endcase
      end

      isr_d = (isr_q & ~isr_clr) | isr_set;
      int_d = ctr_q[0] & |(isr_q & ier_q);
   end

   // Register state
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         prer_q  <= '0;
         ctr_q   <= '0;
         ier_q   <= '0;
         isr_q   <= '0;
         cmd_q   <= '0;
         rxack_q <= 1'b0;
         int_q   <= 1'b0;
      end else begin
         prer_q  <= prer_d;
         ctr_q   <= ctr_d;
         ier_q   <= ier_d;
         isr_q   <= isr_d;
         cmd_q   <= cmd_d;
         rxack_q <= rxack_d;
         int_q   <= int_d;
      end
   end

   // Status register assembly
   always_comb begin
      sr           = '0;
      sr[SR_RXACK] = rxack_q;
      sr[SR_BUSY]  = I2C_busy;
      sr[SR_AL]    = isr_q[ISR_AL];
      sr[SR_TXF]   = tx_full;
      sr[SR_RXE]   = rx_empty;
      sr[SR_TIP]   = tip;
      sr[SR_IF]    = |(isr_q & ier_q);
   end

   // Read data mux
   always_comb begin
      case (Addr)
         ADDR_PRERLO: DataOut = prer_q[7:0];
         ADDR_PRERHI: DataOut = prer_q[15:8];
         ADDR_CTR:    DataOut = {ctr_q, 6'b0};
         ADDR_DATA:   DataOut = rx_head;
         ADDR_CR:     DataOut = sr;
         ADDR_IER:    DataOut = {2'b0, ier_q};
         ADDR_ISR:    DataOut = {2'b0, isr_q};
         ADDR_LVL:    DataOut = {4'(tx_count), 4'(rx_count)};
         default:     DataOut = '0;
      endcase
   end

endmodule

// File: tb/tb_i2c_master_regs_fifo.sv
// Directed bench for i2c_master_regs_fifo: register table plus FIFO/command sequences.
module tb_i2c_master_regs_fifo;

   logic       Clk = 1'b0;
   logic       Rst;
   logic [2:0] Addr;
   logic [7:0] DataIn, DataOut, Tx_data, Rx_data;
   logic       Wr, Rd, Int, Start, Stop, Read, Write, Tx_ack, I2C_en;
   logic       Rx_ack, I2C_busy, I2C_done, I2C_al;
   logic [15:0] Prescale;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit       wr;
      bit [2:0] addr;
      bit [7:0] data;
      bit [7:0] exp;
      string    name;
   } vec_t;

   vec_t vecs[$];

   always #5 Clk = ~Clk;

   i2c_master_regs_fifo #(.DWIDTH(8), .AWIDTH(3), .DEPTH(4), .RX_THRESH(2)) dut (
      .Clk(Clk), .Rst(Rst), .Addr(Addr), .DataIn(DataIn), .DataOut(DataOut),
      .Wr(Wr), .Rd(Rd), .Int(Int), .Start(Start), .Stop(Stop), .Read(Read),
      .Write(Write), .Tx_ack(Tx_ack), .Tx_data(Tx_data), .Prescale(Prescale),
      .I2C_en(I2C_en), .Rx_data(Rx_data), .Rx_ack(Rx_ack), .I2C_busy(I2C_busy),
      .I2C_done(I2C_done), .I2C_al(I2C_al)
   );

   function automatic vec_t mk(bit w, bit [2:0] a, bit [7:0] d, bit [7:0] e, string n);
      vec_t v;
      v.wr = w; v.addr = a; v.data = d; v.exp = e; v.name = n;
      return v;
   endfunction

   task automatic check(string name, logic [15:0] act, logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wr_reg(logic [2:0] a, logic [7:0] d);
      Addr = a; DataIn = d; Wr = 1'b1;
      @(posedge Clk); #1;
      Wr = 1'b0;
   endtask

   task automatic rd_chk(logic [2:0] a, logic [7:0] exp, string name);
      Addr = a;
      @(negedge Clk);
      check(name, {8'h00, DataOut}, {8'h00, exp});
      @(posedge Clk); #1;
   endtask

   task automatic pop_chk(logic [7:0] exp, string name);
      Addr = 3'd3; Rd = 1'b1;
      @(negedge Clk);
      check(name, {8'h00, DataOut}, {8'h00, exp});
      @(posedge Clk); #1;
      Rd = 1'b0;
   endtask

   task automatic pulse(logic d, logic a);
      I2C_done = d; I2C_al = a;
      @(posedge Clk); #1;
      I2C_done = 1'b0; I2C_al = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      Rst = 1'b1; Addr = '0; DataIn = '0; Wr = 1'b0; Rd = 1'b0;
      Rx_data = '0; Rx_ack = 1'b0; I2C_busy = 1'b0; I2C_done = 1'b0; I2C_al = 1'b0;

      vecs.push_back(mk(0, 3'd0, 8'h00, 8'h00, "rst_prerlo"));
      vecs.push_back(mk(0, 3'd1, 8'h00, 8'h00, "rst_prerhi"));
      vecs.push_back(mk(0, 3'd2, 8'h00, 8'h00, "rst_ctr"));
      vecs.push_back(mk(0, 3'd3, 8'h00, 8'h00, "rst_rxdata"));
      vecs.push_back(mk(0, 3'd4, 8'h00, 8'h08, "rst_sr"));
      vecs.push_back(mk(0, 3'd5, 8'h00, 8'h00, "rst_ier"));
      vecs.push_back(mk(0, 3'd6, 8'h00, 8'h00, "rst_isr"));
      vecs.push_back(mk(0, 3'd7, 8'h00, 8'h00, "rst_lvl"));
      vecs.push_back(mk(1, 3'd0, 8'h34, 8'h00, "w_prerlo"));
      vecs.push_back(mk(1, 3'd1, 8'h12, 8'h00, "w_prerhi"));
      vecs.push_back(mk(1, 3'd2, 8'hFF, 8'h00, "w_ctr_ff"));
      vecs.push_back(mk(0, 3'd2, 8'h00, 8'hC0, "ctr_masked"));
      vecs.push_back(mk(1, 3'd2, 8'hC0, 8'h00, "w_ctr"));
      vecs.push_back(mk(0, 3'd0, 8'h00, 8'h34, "prerlo"));
      vecs.push_back(mk(0, 3'd1, 8'h00, 8'h12, "prerhi"));
      vecs.push_back(mk(1, 3'd5, 8'hFF, 8'h00, "w_ier_ff"));
      vecs.push_back(mk(0, 3'd5, 8'h00, 8'h3F, "ier_masked"));
      vecs.push_back(mk(1, 3'd5, 8'h00, 8'h00, "w_ier_0"));
      vecs.push_back(mk(0, 3'd5, 8'h00, 8'h00, "ier_zero"));

      repeat (2) @(posedge Clk);
      #1;
      check("rst_prescale", Prescale, 16'h0000);
      check("rst_cmd", {11'h0, Start, Stop, Read, Write, Tx_ack}, 16'h0000);
      check("rst_en_int", {14'h0, I2C_en, Int}, 16'h0000);
      check("rst_txdata", {8'h00, Tx_data}, 16'h0000);
      Rst = 1'b0;
      @(posedge Clk); #1;

      foreach (vecs[i]) begin
         if (vecs[i].wr) wr_reg(vecs[i].addr, vecs[i].data);
         else rd_chk(vecs[i].addr, vecs[i].exp, vecs[i].name);
      end
      check("prescale", Prescale, 16'h1234);
      check("i2c_en", {15'h0, I2C_en}, 16'h0001);

      // TX write command completed by done
      wr_reg(3'd3, 8'hA1);
      wr_reg(3'd3, 8'hB2);
      check("tx_head", {8'h00, Tx_data}, 16'h00A1);
      rd_chk(3'd7, 8'h20, "lvl_tx2");
      wr_reg(3'd4, 8'h90);
      check("cmd_sta_wr", {11'h0, Start, Stop, Read, Write, Tx_ack}, 16'h0012);
      rd_chk(3'd4, 8'h0A, "sr_tip");
      Rx_ack = 1'b0;
      pulse(1'b1, 1'b0);
      check("cmd_clear", {11'h0, Start, Stop, Read, Write, Tx_ack}, 16'h0000);
      check("tx_head_pop", {8'h00, Tx_data}, 16'h00B2);
      rd_chk(3'd6, 8'h01, "isr_done");
      rd_chk(3'd7, 8'h10, "lvl_tx1");
      check("int_masked", {15'h0, Int}, 16'h0000);
      wr_reg(3'd5, 8'h01);
      check("int_lag", {15'h0, Int}, 16'h0000);
      @(posedge Clk); #1;
      check("int_set", {15'h0, Int}, 16'h0001);
      rd_chk(3'd4, 8'h09, "sr_if");
      wr_reg(3'd6, 8'h01);
      rd_chk(3'd6, 8'h00, "isr_w1c");
      check("int_clear", {15'h0, Int}, 16'h0000);

      // Four RD commands fill RX; threshold at two
      for (int i = 0; i < 4; i++) begin
         wr_reg(3'd4, 8'h20);
         check("cmd_rd", {15'h0, Read}, 16'h0001);
         Rx_data = 8'h10 + 8'(i);
         Rx_ack = (i == 3);
         pulse(1'b1, 1'b0);
         rd_chk(3'd6, (i >= 1) ? 8'h09 : 8'h01, "isr_rxth");
         rd_chk(3'd7, 8'h10 + 8'(i + 1), "lvl_rx");
      end
      Rx_ack = 1'b0;
      rd_chk(3'd4, 8'h81, "sr_rx_full");
      wr_reg(3'd4, 8'h20);
      check("rd_rejected", {15'h0, Read}, 16'h0000);
      rd_chk(3'd6, 8'h29, "isr_rx_full_err");
      for (int i = 0; i < 4; i++) pop_chk(8'h10 + 8'(i), "rx_pop");
      pop_chk(8'h00, "rx_pop_empty");
      rd_chk(3'd7, 8'h10, "lvl_rx_empty");
      wr_reg(3'd6, 8'h3F);

      // Arbitration loss coinciding with done
      wr_reg(3'd4, 8'h10);
      check("cmd_wr", {15'h0, Write}, 16'h0001);
      pulse(1'b1, 1'b1);
      check("al_cmd_clear", {15'h0, Write}, 16'h0000);
      rd_chk(3'd6, 8'h03, "isr_al_done");
      rd_chk(3'd4, 8'hA9, "sr_al");
      check("al_no_pop", {8'h00, Tx_data}, 16'h00B2);
      rd_chk(3'd7, 8'h10, "al_lvl");
      wr_reg(3'd6, 8'h3F);

      // Last TX byte popped raises tx_empty; WR with empty TX is rejected
      wr_reg(3'd4, 8'h10);
      pulse(1'b1, 1'b0);
      rd_chk(3'd6, 8'h05, "isr_tx_empty");
      check("tx_empty_head", {8'h00, Tx_data}, 16'h0000);
      rd_chk(3'd7, 8'h00, "lvl_empty");
      wr_reg(3'd4, 8'h10);
      check("wr_rejected", {15'h0, Write}, 16'h0000);
      rd_chk(3'd6, 8'h25, "isr_tx_empty_err");
      wr_reg(3'd6, 8'h3F);
      wr_reg(3'd4, 8'h30);
      check("rdwr_rejected", {14'h0, Read, Write}, 16'h0000);
      rd_chk(3'd6, 8'h20, "isr_rdwr_err");
      wr_reg(3'd6, 8'h3F);

      // TX full, overflow push, then push and pop together while full
      for (int i = 1; i <= 4; i++) wr_reg(3'd3, 8'(i));
      rd_chk(3'd7, 8'h40, "lvl_tx_full");
      rd_chk(3'd4, 8'h18, "sr_txf");
      wr_reg(3'd3, 8'h05);
      rd_chk(3'd6, 8'h20, "isr_tx_ovf");
      rd_chk(3'd7, 8'h40, "lvl_tx_ovf");
      check("tx_ovf_head", {8'h00, Tx_data}, 16'h0001);
      wr_reg(3'd6, 8'h3F);
      wr_reg(3'd4, 8'h10);
      Addr = 3'd3; DataIn = 8'h05; Wr = 1'b1; I2C_done = 1'b1;
      @(posedge Clk); #1;
      Wr = 1'b0; I2C_done = 1'b0;
      check("pushpop_head", {8'h00, Tx_data}, 16'h0002);
      rd_chk(3'd7, 8'h40, "pushpop_lvl");
      rd_chk(3'd6, 8'h01, "pushpop_isr");
      wr_reg(3'd6, 8'h3F);

      // CR write while busy is ignored, then reset mid-command
      wr_reg(3'd4, 8'h90);
      wr_reg(3'd4, 8'h40);
      check("tip_ignore", {11'h0, Start, Stop, Read, Write, Tx_ack}, 16'h0012);
      rd_chk(3'd6, 8'h20, "isr_tip_err");
      wr_reg(3'd5, 8'h20);
      @(posedge Clk); #1;
      check("int_cmderr", {15'h0, Int}, 16'h0001);
      I2C_busy = 1'b1;
      rd_chk(3'd4, 8'h5B, "sr_busy");
      I2C_busy = 1'b0;
      Addr = 3'd7;
      Rst = 1'b1;
      #2;
      check("rst_async_cmd", {11'h0, Start, Stop, Read, Write, Tx_ack}, 16'h0000);
      check("rst_async_misc", {14'h0, I2C_en, Int}, 16'h0000);
      check("rst_async_pre", Prescale, 16'h0000);
      check("rst_async_tx", {8'h00, Tx_data}, 16'h0000);
      check("rst_async_lvl", {8'h00, DataOut}, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
